// File: rtl/tlb_pkg.sv
// Shared types and constants for the TLB management sequencer.
package tlb_pkg;

    typedef enum logic [2:0] {
        TLBOP_SRCH = 3'd0,
        TLBOP_RD   = 3'd1,
        TLBOP_WR   = 3'd2,
        TLBOP_FILL = 3'd3,
        TLBOP_INV  = 3'd4
    } tlb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } tlb_state_e;

    // Field positions inside raw TLBELO0/1.
    localparam int unsigned ELO_V      = 0;
    localparam int unsigned ELO_D      = 1;
    localparam int unsigned ELO_PLV_LO = 2;
    localparam int unsigned ELO_MAT_LO = 4;
    localparam int unsigned ELO_G      = 6;
    localparam int unsigned ELO_PPN_LO = 8;
    localparam int unsigned ELO_PPN_W  = 20;

    localparam logic [5:0]  ECODE_TLBR = 6'h3F;
    localparam int unsigned INVOP_MAX  = 6;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_half_t;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        tlb_half_t   p0;
        tlb_half_t   p1;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_fill_ptr.sv
// TLBFILL victim pointer: round-robin counter, or a free-running 4-bit
// LFSR when TLB_FILL_LFSR_EN is defined.
module tlb_fill_ptr #(
    parameter int unsigned TLBNUM = 16,
    localparam int unsigned IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          adv,
    output logic [IW-1:0] ptr
);

`ifdef TLB_FILL_LFSR_EN
    logic [3:0] lfsr;
    logic       unused_adv;

    assign unused_adv = adv;

    // x^4+x^3+1, nonzero seed, so entry 0 is never picked.
    always_ff @(posedge clk) begin
        if (!resetn) lfsr <= 4'h1;
        else         lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end

    assign ptr = IW'(lfsr);
`else
    always_ff @(posedge clk) begin
        if (!resetn)  ptr <= '0;
        else if (adv) ptr <= (ptr == IW'(TLBNUM - 1)) ? '0 : ptr + IW'(1);
    end
`endif

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB management instruction sequencer and search-port-1 arbiter.
// Fill victim policy selected by TLB_FILL_LFSR_EN (see tlb_fill_ptr).
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter int unsigned TLBNUM = 16,
    localparam int unsigned IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [2:0]    op_code,
    input  logic [4:0]    inv_op,
    input  logic [9:0]    inv_asid,
    input  logic [18:0]   inv_va,
    input  logic [18:0]   csr_ehi_vppn,
    input  logic [9:0]    csr_asid,
    input  logic [IW-1:0] csr_idx_index,
    input  logic [5:0]    csr_idx_ps,
    input  logic          csr_idx_ne,
    input  logic [31:0]   csr_elo0,
    input  logic [31:0]   csr_elo1,
    input  logic [5:0]    csr_ecode,
    input  logic          mem_req,
    input  logic [18:0]   mem_vppn,
    input  logic          mem_va_bit12,
    input  logic [9:0]    mem_asid,
    output logic          mem_grant,
    output logic [18:0]   s1_vppn,
    output logic          s1_va_bit12,
    output logic [9:0]    s1_asid,
    input  logic          s1_found,
    input  logic [IW-1:0] s1_index,
    output logic          tlb_we,
    output logic [IW-1:0] tlb_w_index,
    output logic          tlb_w_e,
    output logic [18:0]   tlb_w_vppn,
    output logic [5:0]    tlb_w_ps,
    output logic [9:0]    tlb_w_asid,
    output logic          tlb_w_g,
    output logic [19:0]   tlb_w_ppn0,
    output logic [1:0]    tlb_w_plv0,
    output logic [1:0]    tlb_w_mat0,
    output logic          tlb_w_d0,
    output logic          tlb_w_v0,
    output logic [19:0]   tlb_w_ppn1,
    output logic [1:0]    tlb_w_plv1,
    output logic [1:0]    tlb_w_mat1,
    output logic          tlb_w_d1,
    output logic          tlb_w_v1,
    output logic [IW-1:0] tlb_r_index,
    input  logic          tlb_r_e,
    input  logic [18:0]   tlb_r_vppn,
    input  logic [5:0]    tlb_r_ps,
    input  logic [9:0]    tlb_r_asid,
    input  logic          tlb_r_g,
    input  logic [19:0]   tlb_r_ppn0,
    input  logic [1:0]    tlb_r_plv0,
    input  logic [1:0]    tlb_r_mat0,
    input  logic          tlb_r_d0,
    input  logic          tlb_r_v0,
    input  logic [19:0]   tlb_r_ppn1,
    input  logic [1:0]    tlb_r_plv1,
    input  logic [1:0]    tlb_r_mat1,
    input  logic          tlb_r_d1,
    input  logic          tlb_r_v1,
    output logic          tlb_inv_valid,
    output logic [4:0]    tlb_inv_op,
    output logic [9:0]    tlb_inv_asid,
    output logic [18:0]   tlb_inv_va,
    output logic          op_done,
    output logic          op_err,
    output logic          srch_found,
    output logic [IW-1:0] srch_index,
    output logic          rd_valid,
    output tlb_entry_t    rd_bundle
);

    tlb_state_e    state, state_next;
    logic          accept;
    logic [2:0]    op_q;
    logic [IW-1:0] fill_ptr;
    logic          fill_adv, we_set, inv_set;
    logic          is_srch, is_rd, is_inv, op_illegal, inv_bad, in_issue;
    logic          unused_bits;

    // mem_req is implied by the mem stage holding its inputs; ELO reserved bits unused.
    assign unused_bits = ^{mem_req, csr_elo0[31:28], csr_elo0[7], csr_elo1[31:28], csr_elo1[7]};

    assign is_srch    = (op_q == TLBOP_SRCH);
    assign is_rd      = (op_q == TLBOP_RD);
    assign is_inv     = (op_q == TLBOP_INV);
    assign op_illegal = (op_q > 3'(TLBOP_INV));
    assign inv_bad    = (tlb_inv_op > 5'(INVOP_MAX));
    assign in_issue   = (state == ST_ISSUE);

    assign fill_adv = accept && (op_code == TLBOP_FILL);
    assign we_set   = accept && ((op_code == TLBOP_WR) || (op_code == TLBOP_FILL));
    assign inv_set  = accept && (op_code == TLBOP_INV) && (inv_op <= 5'(INVOP_MAX));

    tlb_fill_ptr #(.TLBNUM(TLBNUM)) u_fill_ptr (
        .clk    (clk),
        .resetn (resetn),
        .adv    (fill_adv),
        .ptr    (fill_ptr)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (op_valid) begin
                    accept     = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Search port 1 belongs to the mem stage except while TLBSRCH is issuing.
    assign mem_grant   = !(in_issue && is_srch);
    assign s1_vppn     = mem_grant ? mem_vppn     : tlb_w_vppn;
    assign s1_va_bit12 = mem_grant ? mem_va_bit12 : 1'b0;
    assign s1_asid     = mem_grant ? mem_asid     : tlb_w_asid;

    // Control strobes and result flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_ready      <= 1'b1;
            op_done       <= 1'b0;
            op_err        <= 1'b0;
            tlb_we        <= 1'b0;
            tlb_inv_valid <= 1'b0;
            rd_valid      <= 1'b0;
            srch_found    <= 1'b0;
            srch_index    <= '0;
        end else begin
            op_ready      <= (state_next == ST_IDLE);
            op_done       <= in_issue;
            op_err        <= in_issue && (op_illegal || (is_inv && inv_bad));
            tlb_we        <= we_set;
            tlb_inv_valid <= inv_set;
            rd_valid      <= in_issue && is_rd;
            if (in_issue && is_srch) begin
                srch_found <= s1_found;
                srch_index <= s1_index;
            end
        end
    end

    // Operands captured at accept; later CSR changes cannot reach the in-flight op.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_q         <= '0;
            tlb_w_index  <= '0;
            tlb_r_index  <= '0;
            tlb_w_e      <= 1'b0;
            tlb_w_vppn   <= '0;
            tlb_w_ps     <= '0;
            tlb_w_asid   <= '0;
            tlb_w_g      <= 1'b0;
            tlb_w_ppn0   <= '0;
            tlb_w_plv0   <= '0;
            tlb_w_mat0   <= '0;
            tlb_w_d0     <= 1'b0;
            tlb_w_v0     <= 1'b0;
            tlb_w_ppn1   <= '0;
            tlb_w_plv1   <= '0;
            tlb_w_mat1   <= '0;
            tlb_w_d1     <= 1'b0;
            tlb_w_v1     <= 1'b0;
            tlb_inv_op   <= '0;
            tlb_inv_asid <= '0;
            tlb_inv_va   <= '0;
            rd_bundle    <= '0;
        end else begin
            if (accept) begin
                op_q         <= op_code;
                tlb_w_index  <= (op_code == TLBOP_FILL) ? fill_ptr : csr_idx_index;
                tlb_r_index  <= csr_idx_index;
                tlb_w_e      <= (csr_ecode == ECODE_TLBR) | ~csr_idx_ne;
                tlb_w_vppn   <= csr_ehi_vppn;
                tlb_w_ps     <= csr_idx_ps;
                tlb_w_asid   <= csr_asid;
                tlb_w_g      <= csr_elo0[ELO_G] & csr_elo1[ELO_G];
                tlb_w_ppn0   <= csr_elo0[ELO_PPN_LO +: ELO_PPN_W];
                tlb_w_plv0   <= csr_elo0[ELO_PLV_LO +: 2];
                tlb_w_mat0   <= csr_elo0[ELO_MAT_LO +: 2];
                tlb_w_d0     <= csr_elo0[ELO_D];
                tlb_w_v0     <= csr_elo0[ELO_V];
                tlb_w_ppn1   <= csr_elo1[ELO_PPN_LO +: ELO_PPN_W];
                tlb_w_plv1   <= csr_elo1[ELO_PLV_LO +: 2];
                tlb_w_mat1   <= csr_elo1[ELO_MAT_LO +: 2];
                tlb_w_d1     <= csr_elo1[ELO_D];
                tlb_w_v1     <= csr_elo1[ELO_V];
                tlb_inv_op   <= inv_op;
                tlb_inv_asid <= inv_asid;
                tlb_inv_va   <= inv_va;
            end
            if (in_issue && is_rd) begin
                rd_bundle.e    <= tlb_r_e;
                rd_bundle.vppn <= tlb_r_vppn;
                rd_bundle.ps   <= tlb_r_ps;
                rd_bundle.asid <= tlb_r_asid;
                rd_bundle.g    <= tlb_r_g;
                rd_bundle.p0   <= '{ppn: tlb_r_ppn0, plv: tlb_r_plv0, mat: tlb_r_mat0,
                                    d: tlb_r_d0, v: tlb_r_v0};
                rd_bundle.p1   <= '{ppn: tlb_r_ppn1, plv: tlb_r_plv1, mat: tlb_r_mat1,
                                    d: tlb_r_d1, v: tlb_r_v1};
            end
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a small behavioural 16-entry TLB attached.
module tb_tlb_op_ctrl;
    import tlb_pkg::*;

    localparam int unsigned TLBNUM = 16;
    localparam int unsigned IW     = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          op_valid, op_ready;
    logic [2:0]    op_code;
    logic [4:0]    inv_op;
    logic [9:0]    inv_asid;
    logic [18:0]   inv_va;
    logic [18:0]   csr_ehi_vppn;
    logic [9:0]    csr_asid;
    logic [IW-1:0] csr_idx_index;
    logic [5:0]    csr_idx_ps;
    logic          csr_idx_ne;
    logic [31:0]   csr_elo0, csr_elo1;
    logic [5:0]    csr_ecode;
    logic          mem_req, mem_va_bit12, mem_grant;
    logic [18:0]   mem_vppn, s1_vppn;
    logic [9:0]    mem_asid, s1_asid;
    logic          s1_va_bit12, s1_found;
    logic [IW-1:0] s1_index;
    logic          tlb_we, tlb_w_e, tlb_w_g;
    logic [IW-1:0] tlb_w_index, tlb_r_index;
    logic [18:0]   tlb_w_vppn;
    logic [5:0]    tlb_w_ps;
    logic [9:0]    tlb_w_asid;
    logic [19:0]   tlb_w_ppn0, tlb_w_ppn1, tlb_r_ppn0, tlb_r_ppn1;
    logic [1:0]    tlb_w_plv0, tlb_w_plv1, tlb_w_mat0, tlb_w_mat1;
    logic [1:0]    tlb_r_plv0, tlb_r_plv1, tlb_r_mat0, tlb_r_mat1;
    logic          tlb_w_d0, tlb_w_v0, tlb_w_d1, tlb_w_v1;
    logic          tlb_r_d0, tlb_r_v0, tlb_r_d1, tlb_r_v1;
    logic          tlb_r_e, tlb_r_g;
    logic [18:0]   tlb_r_vppn;
    logic [5:0]    tlb_r_ps;
    logic [9:0]    tlb_r_asid;
    logic          tlb_inv_valid;
    logic [4:0]    tlb_inv_op;
    logic [9:0]    tlb_inv_asid;
    logic [18:0]   tlb_inv_va;
    logic          op_done, op_err, srch_found, rd_valid;
    logic [IW-1:0] srch_index;
    tlb_entry_t    rd_bundle;

    int n_checks = 0;
    int n_pass   = 0;
    int we_cnt   = 0;
    int inv_cnt  = 0;
    int done_cnt = 0;
    int we0, inv0, done0;

    // Snapshots taken inside run_op.
    logic          pre_grant, iss_we, iss_w_e, iss_w_g, iss_grant, iss_inv_valid, iss_ready, iss_va12;
    logic [IW-1:0] iss_w_index, iss_r_index;
    logic [18:0]   iss_s1_vppn, iss_inv_va, done_s1_vppn;
    logic [4:0]    iss_inv_op;
    logic [9:0]    iss_inv_asid;
    logic          done_done, done_err, done_found, done_rd_valid, done_grant, done_ready;
    logic [IW-1:0] done_index;
    tlb_entry_t    done_rd;

    tlb_entry_t mdl [TLBNUM];

    always #5 clk = ~clk;

    tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
        .csr_ehi_vppn(csr_ehi_vppn), .csr_asid(csr_asid), .csr_idx_index(csr_idx_index),
        .csr_idx_ps(csr_idx_ps), .csr_idx_ne(csr_idx_ne), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
        .csr_ecode(csr_ecode), .mem_req(mem_req), .mem_vppn(mem_vppn), .mem_va_bit12(mem_va_bit12),
        .mem_asid(mem_asid), .mem_grant(mem_grant), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12),
        .s1_asid(s1_asid), .s1_found(s1_found), .s1_index(s1_index),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e), .tlb_w_vppn(tlb_w_vppn),
        .tlb_w_ps(tlb_w_ps), .tlb_w_asid(tlb_w_asid), .tlb_w_g(tlb_w_g),
        .tlb_w_ppn0(tlb_w_ppn0), .tlb_w_plv0(tlb_w_plv0), .tlb_w_mat0(tlb_w_mat0),
        .tlb_w_d0(tlb_w_d0), .tlb_w_v0(tlb_w_v0),
        .tlb_w_ppn1(tlb_w_ppn1), .tlb_w_plv1(tlb_w_plv1), .tlb_w_mat1(tlb_w_mat1),
        .tlb_w_d1(tlb_w_d1), .tlb_w_v1(tlb_w_v1),
        .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e), .tlb_r_vppn(tlb_r_vppn), .tlb_r_ps(tlb_r_ps),
        .tlb_r_asid(tlb_r_asid), .tlb_r_g(tlb_r_g),
        .tlb_r_ppn0(tlb_r_ppn0), .tlb_r_plv0(tlb_r_plv0), .tlb_r_mat0(tlb_r_mat0),
        .tlb_r_d0(tlb_r_d0), .tlb_r_v0(tlb_r_v0),
        .tlb_r_ppn1(tlb_r_ppn1), .tlb_r_plv1(tlb_r_plv1), .tlb_r_mat1(tlb_r_mat1),
        .tlb_r_d1(tlb_r_d1), .tlb_r_v1(tlb_r_v1),
        .tlb_inv_valid(tlb_inv_valid), .tlb_inv_op(tlb_inv_op), .tlb_inv_asid(tlb_inv_asid),
        .tlb_inv_va(tlb_inv_va), .op_done(op_done), .op_err(op_err),
        .srch_found(srch_found), .srch_index(srch_index), .rd_valid(rd_valid), .rd_bundle(rd_bundle)
    );

    // Behavioural TLB: write on tlb_we, combinational read and search.
    initial for (int i = 0; i < int'(TLBNUM); i++) mdl[i] = '0;

    always @(posedge clk) begin
        if (tlb_we)
            mdl[tlb_w_index] <= '{e: tlb_w_e, vppn: tlb_w_vppn, ps: tlb_w_ps, asid: tlb_w_asid, g: tlb_w_g,
                                  p0: '{ppn: tlb_w_ppn0, plv: tlb_w_plv0, mat: tlb_w_mat0, d: tlb_w_d0, v: tlb_w_v0},
                                  p1: '{ppn: tlb_w_ppn1, plv: tlb_w_plv1, mat: tlb_w_mat1, d: tlb_w_d1, v: tlb_w_v1}};
    end

    always_comb begin
        s1_found = 1'b0;
        s1_index = '0;
        for (int i = 0; i < int'(TLBNUM); i++) begin
            if (mdl[i].e && mdl[i].vppn == s1_vppn && (mdl[i].g || mdl[i].asid == s1_asid)) begin
                s1_found = 1'b1;
                s1_index = IW'(i);
            end
        end
    end

    assign tlb_r_e    = mdl[tlb_r_index].e;
    assign tlb_r_vppn = mdl[tlb_r_index].vppn;
    assign tlb_r_ps   = mdl[tlb_r_index].ps;
    assign tlb_r_asid = mdl[tlb_r_index].asid;
    assign tlb_r_g    = mdl[tlb_r_index].g;
    assign tlb_r_ppn0 = mdl[tlb_r_index].p0.ppn;
    assign tlb_r_plv0 = mdl[tlb_r_index].p0.plv;
    assign tlb_r_mat0 = mdl[tlb_r_index].p0.mat;
    assign tlb_r_d0   = mdl[tlb_r_index].p0.d;
    assign tlb_r_v0   = mdl[tlb_r_index].p0.v;
    assign tlb_r_ppn1 = mdl[tlb_r_index].p1.ppn;
    assign tlb_r_plv1 = mdl[tlb_r_index].p1.plv;
    assign tlb_r_mat1 = mdl[tlb_r_index].p1.mat;
    assign tlb_r_d1   = mdl[tlb_r_index].p1.d;
    assign tlb_r_v1   = mdl[tlb_r_index].p1.v;

    always @(posedge clk) begin
        if (tlb_we)        we_cnt   = we_cnt + 1;
        if (tlb_inv_valid) inv_cnt  = inv_cnt + 1;
        if (op_done)       done_cnt = done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one op; snapshot outputs in ISSUE and DONE. scramble alters CSRs after accept.
    task automatic run_op(input logic [2:0] code, input bit hold, input bit scramble);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!op_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_before_op", 32'(op_ready), 1);
        op_valid = 1'b1;
        op_code  = code;
        we0 = we_cnt; inv0 = inv_cnt; done0 = done_cnt;
        #1 pre_grant = mem_grant;
        @(negedge clk);
        if (!hold) op_valid = 1'b0;
        if (scramble) begin
            csr_idx_index = '0;
            csr_idx_ne    = 1'b1;
            csr_ecode     = 6'h00;
        end
        #1;
        iss_we = tlb_we;  iss_w_index = tlb_w_index; iss_w_e = tlb_w_e; iss_w_g = tlb_w_g;
        iss_grant = mem_grant; iss_s1_vppn = s1_vppn; iss_va12 = s1_va_bit12; iss_r_index = tlb_r_index;
        iss_inv_valid = tlb_inv_valid; iss_inv_op = tlb_inv_op; iss_inv_asid = tlb_inv_asid;
        iss_inv_va = tlb_inv_va; iss_ready = op_ready;
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        done_done = op_done; done_err = op_err; done_found = srch_found; done_index = srch_index;
        done_rd_valid = rd_valid; done_rd = rd_bundle; done_grant = mem_grant; done_ready = op_ready;
        done_s1_vppn = s1_vppn;
    endtask

    initial begin
        resetn = 1'b0; op_valid = 1'b0; op_code = '0;
        inv_op = '0; inv_asid = '0; inv_va = '0;
        csr_ehi_vppn = 19'h00100; csr_asid = 10'd0; csr_idx_index = '0; csr_idx_ps = 6'd12;
        csr_idx_ne = 1'b1; csr_elo0 = '0; csr_elo1 = '0; csr_ecode = 6'h00;
        mem_req = 1'b0; mem_vppn = '0; mem_va_bit12 = 1'b0; mem_asid = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_op_ready",   32'(op_ready), 1);
        check_eq("rst_op_done",    32'(op_done), 0);
        check_eq("rst_op_err",     32'(op_err), 0);
        check_eq("rst_tlb_we",     32'(tlb_we), 0);
        check_eq("rst_inv_valid",  32'(tlb_inv_valid), 0);
        check_eq("rst_rd_valid",   32'(rd_valid), 0);
        check_eq("rst_srch_found", 32'(srch_found), 0);
        check_eq("rst_srch_index", 32'(srch_index), 0);
        check_eq("rst_mem_grant",  32'(mem_grant), 1);
        resetn = 1'b1;

        // 17 FILLs walk the round-robin pointer 0..15 and wrap to 0; entries stay invalid (ne=1).
        for (int i = 0; i < 17; i++) begin
            run_op(TLBOP_FILL, 1'b0, 1'b0);
            check_eq("fill_w_index", 32'(iss_w_index), i % 16);
            check_eq("fill_we",      32'(iss_we), 1);
            check_eq("fill_we_count", we_cnt - we0, 1);
            check_eq("fill_done",    32'(done_done), 1);
        end
        check_eq("fill_w_e", 32'(iss_w_e), 0);

        // WR at 5: refill ecode forces e=1; G only in ELO0 gives g=0; CSRs scrambled after accept.
        csr_idx_index = 4'd5; csr_idx_ne = 1'b1; csr_ecode = 6'h3F;
        csr_ehi_vppn = 19'h00AAA; csr_asid = 10'd1; csr_elo0 = 32'h41; csr_elo1 = 32'h01;
        run_op(TLBOP_WR, 1'b0, 1'b1);
        check_eq("wr5_we",       32'(iss_we), 1);
        check_eq("wr5_w_index",  32'(iss_w_index), 5);
        check_eq("wr5_w_e",      32'(iss_w_e), 1);
        check_eq("wr5_w_g",      32'(iss_w_g), 0);
        check_eq("wr5_we_count", we_cnt - we0, 1);
        check_eq("wr5_ready_issue", 32'(iss_ready), 0);
        check_eq("wr5_ready_done",  32'(done_ready), 0);

        // WR at 7: ne=0 gives e=1.
        csr_idx_index = 4'd7; csr_idx_ne = 1'b0; csr_ecode = 6'h00;
        csr_ehi_vppn = 19'h12345; csr_asid = 10'd3; csr_elo0 = 32'h01; csr_elo1 = 32'h01;
        run_op(TLBOP_WR, 1'b0, 1'b0);
        check_eq("wr7_w_index", 32'(iss_w_index), 7);
        check_eq("wr7_w_e",     32'(iss_w_e), 1);

        // SRCH hit while the mem stage keeps requesting.
        mem_req = 1'b1; mem_vppn = 19'h0ABCD; mem_asid = 10'd9; mem_va_bit12 = 1'b1;
        csr_ehi_vppn = 19'h12345; csr_asid = 10'd3;
        run_op(TLBOP_SRCH, 1'b0, 1'b0);
        check_eq("srch_grant_idle",  32'(pre_grant), 1);
        check_eq("srch_grant_issue", 32'(iss_grant), 0);
        check_eq("srch_grant_done",  32'(done_grant), 1);
        check_eq("srch_s1_vppn",     32'(iss_s1_vppn), 'h12345);
        check_eq("srch_s1_va12",     32'(iss_va12), 0);
        check_eq("srch_mem_pass",    32'(done_s1_vppn), 'h0ABCD);
        check_eq("srch_done",        32'(done_done), 1);
        check_eq("srch_found",       32'(done_found), 1);
        check_eq("srch_index",       32'(done_index), 7);

        // SRCH with a different ASID misses the non-global entry.
        csr_asid = 10'd4;
        run_op(TLBOP_SRCH, 1'b0, 1'b0);
        check_eq("srch_miss_found", 32'(done_found), 0);
        mem_req = 1'b0;

        // RD at 7.
        csr_idx_index = 4'd7;
        run_op(TLBOP_RD, 1'b0, 1'b0);
        check_eq("rd_r_index", 32'(iss_r_index), 7);
        check_eq("rd_valid",   32'(done_rd_valid), 1);
        check_eq("rd_vppn",    32'(done_rd.vppn), 'h12345);
        check_eq("rd_asid",    32'(done_rd.asid), 3);
        check_eq("rd_e",       32'(done_rd.e), 1);
        check_eq("rd_ps",      32'(done_rd.ps), 12);

        // INV op 5 pulses once with latched operands.
        inv_op = 5'd5; inv_asid = 10'h155; inv_va = 19'h1ABCD;
        run_op(TLBOP_INV, 1'b0, 1'b0);
        check_eq("inv5_valid",  32'(iss_inv_valid), 1);
        check_eq("inv5_op",     32'(iss_inv_op), 5);
        check_eq("inv5_asid",   32'(iss_inv_asid), 'h155);
        check_eq("inv5_va",     32'(iss_inv_va), 'h1ABCD);
        check_eq("inv5_count",  inv_cnt - inv0, 1);
        check_eq("inv5_err",    32'(done_err), 0);

        // INV op 9 is rejected.
        inv_op = 5'd9;
        run_op(TLBOP_INV, 1'b0, 1'b0);
        check_eq("inv9_count", inv_cnt - inv0, 0);
        check_eq("inv9_done",  32'(done_done), 1);
        check_eq("inv9_err",   32'(done_err), 1);

        // Illegal op_code, with op_valid held high while busy.
        run_op(3'd6, 1'b1, 1'b0);
        check_eq("ill_err",      32'(done_err), 1);
        check_eq("ill_we_count", we_cnt - we0, 0);
        check_eq("ill_inv_count", inv_cnt - inv0, 0);
        repeat (3) @(negedge clk);
        check_eq("busy_ignored_done", done_cnt - done0, 1);
        check_eq("busy_ignored_ready", 32'(op_ready), 1);

        // Reset during ISSUE of a WR.
        csr_idx_index = 4'd9;
        op_valid = 1'b1; op_code = TLBOP_WR;
        we0 = we_cnt; done0 = done_cnt;
        @(negedge clk);
        op_valid = 1'b0;
        check_eq("rstiss_we_issue", 32'(tlb_we), 1);
        resetn = 1'b0;
        @(negedge clk);
        check_eq("rstiss_ready", 32'(op_ready), 1);
        check_eq("rstiss_done",  32'(op_done), 0);
        check_eq("rstiss_we",    32'(tlb_we), 0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rstiss_we_count",   we_cnt - we0, 1);
        check_eq("rstiss_done_count", done_cnt - done0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequencer and port arbiter for the 16-entry TLB. It accepts one TLB management instruction at a time from the EX stage: TLBSRCH, TLBRD, TLBWR, TLBFILL or INVTLB. It drives the TLB write, read and invalidate ports, and time-shares TLB search port 1 between load/store translation and TLBSRCH. Results are returned to the CSR unit as registered, one-cycle-valid bundles.

## Interface
Parameters:
- TLBNUM, 16, TLB entry count; index width IW = $clog2(TLBNUM)

Ports (name, direction, width, meaning):
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- op_valid  in  1  instruction request from EX
- op_ready  out  1  controller can accept a request
- op_code  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5..7 illegal
- inv_op / inv_asid / inv_va  in  5/10/19  INVTLB operands, sampled at accept
- csr_ehi_vppn / csr_asid  in  19/10  TLBEHI.VPPN, ASID.ASID
- csr_idx_index / csr_idx_ps / csr_idx_ne  in  IW/6/1  TLBIDX fields
- csr_elo0 / csr_elo1  in  32/32  TLBELO0/1 raw: V[0], D[1], PLV[3:2], MAT[5:4], G[6], PPN[27:8]
- csr_ecode  in  6  ESTAT.Ecode; 0x3F marks TLB refill
- mem_req / mem_vppn / mem_va_bit12 / mem_asid  in  1/19/1/10  load/store lookup
- mem_grant  out  1  port 1 is carrying the mem lookup this cycle
- s1_vppn / s1_va_bit12 / s1_asid  out  19/1/10  to TLB search port 1
- s1_found / s1_index  in  1/IW  from TLB search port 1
- tlb_we, tlb_w_index(IW), tlb_w_e, tlb_w_vppn(19), tlb_w_ps(6), tlb_w_asid(10), tlb_w_g, tlb_w_{ppn,plv,mat,d,v}{0,1}  out  to TLB write port
- tlb_r_index  out  IW  to TLB read port
- tlb_r_*  in  mirror of the TLB read port outputs
- tlb_inv_valid / tlb_inv_op / tlb_inv_asid / tlb_inv_va  out  1/5/10/19  to TLB invalidate port
- op_done  out  1  one-cycle pulse when the instruction retires
- op_err  out  1  with op_done: illegal op_code, or inv_op > 6
- srch_found / srch_index  out  1/IW  TLBSRCH result, valid with op_done
- rd_valid / rd_bundle  out  1/…  TLBRD: entry fields (e, vppn, ps, asid, g, both halves), valid with op_done

## Operation
- FSM with three states:
  - IDLE: op_ready=1.
  - ISSUE: operands latched at accept; TLB side-effect happens here.
  - DONE: op_done=1 → IDLE.
- Accept on op_valid && op_ready. Each instruction takes exactly 2 cycles after accept.
- SRCH: in ISSUE, drive s1 with {csr_ehi_vppn, 0, csr_asid} and register s1_found/s1_index.
- RD: in ISSUE, tlb_r_index = latched csr_idx_index and tlb_r_* are registered. rd_valid=1 in DONE.
- WR: one tlb_we pulse in ISSUE at latched csr_idx_index.
- FILL: one tlb_we pulse in ISSUE at the fill pointer, then advance the pointer.
- Write data for WR and FILL:
  - tlb_w_e = (csr_ecode==0x3F) | ~csr_idx_ne
  - tlb_w_g = elo0.G & elo1.G
  - ps, vppn and asid come from the CSRs.
- INV: in ISSUE, pulse tlb_inv_valid for one cycle with the latched operands. If inv_op > 6: no pulse, and op_err=1 in DONE.
- Illegal op_code: no TLB side-effect; op_err=1 in DONE.
- Arbitration: mem_grant = ~(state==ISSUE && op==SRCH). When granted, the s1 outputs pass the mem inputs combinationally. SRCH has priority; the mem stage must hold its request while mem_grant=0.
- CSR operands are latched at accept. Changes to them after accept have no effect on the in-flight instruction.

## Timing
- Reset values:
  - state IDLE; op_ready=1
  - op_done, op_err, tlb_we, tlb_inv_valid, rd_valid, srch_found = 0
  - srch_index = 0; fill pointer = 0 (LFSR seed 1)
  - mem_grant=1
- Accept at cycle t, side-effect at t+1, op_done at t+2, next accept no earlier than t+3.
- A TLB write lands at the edge ending ISSUE and is visible to searches from DONE onward.
- Fill pointer wraps from TLBNUM-1 to 0.
- Reset asserted in ISSUE or DONE:
  - return to IDLE at the next edge; no op_done.
  - tlb_we / tlb_inv_valid are deasserted from that edge onward.
- op_valid asserted while busy is ignored (no queueing).

## Configuration
- TLB_FILL_LFSR_EN defined: the fill pointer is a 4-bit LFSR (x^4+x^3+1) with nonzero seed 1, advanced every cycle. Pseudo-random victim; index 0 is never selected.
- TLB_FILL_LFSR_EN undefined: the fill pointer is a round-robin counter, incremented only on FILL.

## Structure
- Package tlb_pkg holds:
  - the op_code enum (TLBOP_SRCH..TLBOP_INV)
  - the FSM state enum
  - the TLBELO bit-position constants
  - the ECODE_TLBR = 6'h3F constant
  - the INVOP_MAX = 6 constant
- One sub-module, tlb_fill_ptr, holds the counter/LFSR behind TLB_FILL_LFSR_EN.

## Test plan
- Round-robin FILL: reset, then 17 FILL ops → tlb_w_index sequence 0,1,…,15,0, one tlb_we per op, op_done 2 cycles after each accept.
- WR with csr_idx_ne=1, csr_ecode=0x3F, elo0.G=1, elo1.G=0 at index 5 → one tlb_we, w_index=5, w_e=1, w_g=0.
- SRCH after WR of vppn 0x12345 / asid 3 at index 7, with mem_req=1 throughout:
  - mem_grant=0 only in ISSUE
  - op_done with srch_found=1, srch_index=7
- INV with inv_op=5 → one tlb_inv_valid pulse (op 5, latched asid/va). INV with inv_op=9 → no pulse, op_err=1.
- RD at index 7 → tlb_r_index=7 in ISSUE; rd_bundle.vppn=0x12345, rd_valid=1 in DONE.
- resetn low during ISSUE of a WR → no op_done, op_ready=1 the next cycle, no further tlb_we.
